// File: rtl/instruction_cache_if.sv
// Bundle for the cache's CPU-side fetch port and ROM-side read port.
// master = controller/ROM side, slave = the cache itself.
interface instruction_cache_if #(
    parameter int ADDR_SIZE = 64
);
    logic                 cpu_enable;
    logic [ADDR_SIZE-1:0] cpu_addr;
    logic [31:0]          cpu_data;
    logic                 cpu_busy;
    logic                 mem_enable;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [31:0]          mem_data;
    logic                 mem_busy;
    logic                 invalidate;

    modport master (
        output cpu_enable, cpu_addr, invalidate, mem_data, mem_busy,
        input  cpu_data, cpu_busy, mem_enable, mem_addr
    );

    modport slave (
        input  cpu_enable, cpu_addr, invalidate, mem_data, mem_busy,
        output cpu_data, cpu_busy, mem_enable, mem_addr
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache in front of the ROM.
// Uses the ROM's own enable/busy/data protocol on both sides.
module instruction_cache #(
    parameter int ADDR_SIZE     = 64,
    parameter int L2_LINE_WORDS = 2,
    parameter int L2_LINES      = 4
) (
    input logic                clock,
    input logic                reset,
    instruction_cache_if.slave bus
);
    localparam int WORDS  = 1 << L2_LINE_WORDS;
    localparam int LINES  = 1 << L2_LINES;
    localparam int IDX_LO = L2_LINE_WORDS + 2;
    localparam int TAG_LO = IDX_LO + L2_LINES;
    localparam int TAG_W  = ADDR_SIZE - TAG_LO;

    localparam logic [L2_LINE_WORDS-1:0] LAST = '1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] FILL   = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [ADDR_SIZE-1:0]     addr_q, addr_d;
    logic [L2_LINE_WORDS-1:0] word_cnt_q, word_cnt_d;
    logic                     pending_inv_q, pending_inv_d;
    logic                     seen_busy_q, seen_busy_d;
    logic                     cpu_busy_q, cpu_busy_d;
    logic [31:0]              cpu_data_q, cpu_data_d;
    logic                     mem_enable_q, mem_enable_d;
    logic [ADDR_SIZE-1:0]     mem_addr_q, mem_addr_d;
    logic [LINES-1:0]         valid_q, valid_d;
    logic [TAG_W-1:0]         tag_q [LINES];
    logic [TAG_W-1:0]         tag_d [LINES];
    logic [31:0]              data_q [LINES][WORDS];
    logic [31:0]              data_d [LINES][WORDS];

    logic [L2_LINE_WORDS-1:0] off;
    logic [L2_LINES-1:0]      idx;
    logic [TAG_W-1:0]         tag;
    logic                     hit;

    assign off = addr_q[IDX_LO-1:2];
    assign idx = addr_q[TAG_LO-1:IDX_LO];
    assign tag = addr_q[ADDR_SIZE-1:TAG_LO];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        word_cnt_d    = word_cnt_q;
        pending_inv_d = pending_inv_q;
        seen_busy_d   = seen_busy_q;
        cpu_data_d    = cpu_data_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        data_d        = data_q;

        unique case (state_q)
            IDLE: begin
                if (pending_inv_q || bus.invalidate) begin
                    valid_d       = '0;
                    pending_inv_d = 1'b0;
                end else if (bus.cpu_enable) begin
                    addr_d  = bus.cpu_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_data_d = data_q[idx][off];
                    state_d    = DONE;
                end else begin
                    word_cnt_d  = '0;
                    seen_busy_d = 1'b0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                // A ROM word is done on the busy 1 -> 0 transition
                if (bus.mem_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    seen_busy_d = 1'b0;
                    data_d[idx][word_cnt_q] = bus.mem_data;
                    if (word_cnt_q == LAST) begin
                        tag_d[idx]   = tag;
                        valid_d[idx] = 1'b1;
                        state_d      = LOOKUP;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        state_d    = GAP;
                    end
                end
            end
            GAP:     state_d = FILL;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && bus.invalidate) begin
            pending_inv_d = 1'b1;
        end
    end

    // Outputs are registered from the next state
    always_comb begin
        cpu_busy_d   = (state_d == LOOKUP) || (state_d == FILL) ||
                       (state_d == GAP);
        mem_enable_d = (state_d == FILL);
        mem_addr_d   = mem_addr_q;
        if (state_d == FILL) begin
            mem_addr_d = {tag, idx, word_cnt_d, 2'b00};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            word_cnt_q    <= '0;
            pending_inv_q <= 1'b0;
            seen_busy_q   <= 1'b0;
            cpu_busy_q    <= 1'b0;
            cpu_data_q    <= '0;
            mem_enable_q  <= 1'b0;
            mem_addr_q    <= '0;
            valid_q       <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            word_cnt_q    <= word_cnt_d;
            pending_inv_q <= pending_inv_d;
            seen_busy_q   <= seen_busy_d;
            cpu_busy_q    <= cpu_busy_d;
            cpu_data_q    <= cpu_data_d;
            mem_enable_q  <= mem_enable_d;
            mem_addr_q    <= mem_addr_d;
            valid_q       <= valid_d;
            tag_q         <= tag_d;
        end
    end

    always_ff @(posedge clock) begin
        data_q <= data_d;
    end

    assign bus.cpu_busy   = cpu_busy_q;
    assign bus.cpu_data   = cpu_data_q;
    assign bus.mem_enable = mem_enable_q;
    assign bus.mem_addr   = mem_addr_q;
endmodule
